plot_sink: RTL and testbench
============================

# plot_sink

Buffered consumer for the pixel plot stream produced by the draw multiplexer. It accepts one plot request per clock (x, y, colour, plot strobe) without backpressure and stores it in a FIFO. It converts each request to a linear 160x120 framebuffer address and drains requests to the framebuffer write port under a valid/ready handshake. It sits between the draw mux and the framebuffer, decoupling draw bursts from framebuffer write stalls.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..64
- X_MAX, 160, screen width; valid x is 0..X_MAX-1
- Y_MAX, 120, screen height; valid y is 0..Y_MAX-1

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-high reset
- x_in  in  10  plot x coordinate
- y_in  in  10  plot y coordinate
- colour_in  in  3  plot colour
- plot_in  in  1  plot strobe; request sampled on every clk edge where high
- fb_addr  out  15  framebuffer address, y*160+x
- fb_data  out  3  framebuffer colour
- fb_wren  out  1  write request valid
- fb_ready  in  1  framebuffer accepts write this cycle
- level  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the output stage
- full  out  1  level == DEPTH
- empty  out  1  level == 0 and output stage idle
- overflow  out  1  sticky; set when a request is dropped

## Operation
- Entry format: {addr[14:0], colour[2:0]}. Address is computed at push as (y<<7)+(y<<5)+x, truncated to 15 bits.
- Push: plot_in high, and either full low or a pop occurs in the same cycle. A push and pop in the same cycle leave level unchanged.
- Drop: plot_in high while full with no pop that cycle. The entry is discarded, overflow is set, and FIFO contents are unchanged.
- Output stage FSM, two states:
  - IDLE: fb_wren=0. If level>0, pop the head into the fb_addr/fb_data registers and go to WRITE.
  - WRITE: fb_wren=1 with fb_addr/fb_data held stable. On fb_ready=1, the write completes:
    - if level>0, pop the next entry the same edge and stay in WRITE (back-to-back, one write per cycle);
    - otherwise go to IDLE.
- FIFO pointers wrap modulo DEPTH. level is a separate counter, DEPTH+1 states.
- fb_ready is ignored in IDLE.
- Order is strict FIFO; no coalescing of duplicate coordinates.

## Timing
- Reset (async assert): FSM=IDLE, pointers=0, level=0, fb_wren=0, fb_addr=0, fb_data=0, full=0, empty=1, overflow=0. FIFO RAM contents are don't-care.
- Latency, empty sink: plot_in sampled at edge N -> FIFO write at N -> pop at N+1 -> fb_wren=1 after N+1, i.e. 2 cycles.
- Throughput: 1 write/cycle while fb_ready held high and the FIFO is non-empty.
- fb_addr/fb_data/fb_wren must not change while fb_wren=1 and fb_ready=0.
- Reset asserted mid-transfer: the pending write is abandoned and fb_wren drops immediately (asynchronous). All queued entries are lost.
- full/empty/level are registered and reflect state after the current edge.
- overflow clears only on reset.

## Configuration
- PLOT_SINK_CLIP_EN defined:
  - a request with x_in>=X_MAX or y_in>=Y_MAX is discarded at push;
  - it does not occupy the FIFO and does not set overflow;
  - it is discarded even when full.
- Undefined: no coordinate check. Out-of-range requests are queued with the truncated address, and a full-FIFO drop sets overflow as normal.

## Test plan
- Single plot x=5,y=3,colour=3'b100, fb_ready=1 -> fb_wren high for exactly 1 cycle, 2 cycles after the strobe, fb_addr=485, fb_data=4; empty returns to 1.
- 20 consecutive plots (x=0..19, y=0), fb_ready=0, DEPTH=16 -> level=16 and full=1; entry x=0 is held in the output stage; 3 requests dropped; overflow=1. Then fb_ready=1 -> 17 writes of addr 0..16 in order, back-to-back.
- fb_ready toggling 1,0,1,0 during a 4-entry drain -> each addr held stable while fb_ready=0; 4 writes, no duplicates or losses.
- Full FIFO, fb_wren=1, fb_ready=1, plot_in=1 same cycle -> push accepted, level stays 16, overflow stays 0.
- With PLOT_SINK_CLIP_EN: plot x=160,y=0 then x=159,y=119 -> only addr 19199 written, overflow=0. Without the macro, addr 160 is written first.
- reset pulsed while fb_wren=1 with level=5 -> fb_wren=0 immediately; after release level=0, empty=1, and no writes occur.

Source files
------------

// File: rtl/plot_sink_if.sv
// Plot stream and framebuffer write port bundle for plot_sink.
// The master drives plot requests and fb_ready. The slave (the sink) drives the framebuffer write.
interface plot_sink_if;
   logic [9:0]  x_in;
   logic [9:0]  y_in;
   logic [2:0]  colour_in;
   logic        plot_in;
   logic [14:0] fb_addr;
   logic [2:0]  fb_data;
   logic        fb_wren;
   logic        fb_ready;

   // Handshake: a write completes on every clk edge where fb_wren and fb_ready are both high.
   // fb_addr/fb_data/fb_wren stay stable while fb_wren=1 and fb_ready=0.
   // plot_in has no backpressure. A request is sampled on every edge where plot_in is high.
   modport master (
      output x_in, y_in, colour_in, plot_in, fb_ready,
      input  fb_addr, fb_data, fb_wren
   );

   modport slave (
      input  x_in, y_in, colour_in, plot_in, fb_ready,
      output fb_addr, fb_data, fb_wren
   );
endinterface

// File: rtl/plot_sink.sv
// Buffered plot consumer: FIFO of {addr, colour} drained to the framebuffer by a two-state output stage.
// Optional PLOT_SINK_CLIP_EN discards off-screen requests before they reach the FIFO.
module plot_sink #(
   parameter int DEPTH = 16,
   parameter int X_MAX = 160,
   parameter int Y_MAX = 120,
   localparam int PW = $clog2(DEPTH),
   localparam int LW = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   plot_sink_if.slave    bus,
   output logic [LW-1:0] level,
   output logic          full,
   output logic          empty,
   output logic          overflow,
   output logic          o_req_offscreen,
   output logic          o_state_dbg
);

   typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

   localparam logic [9:0]    X_LIM = 10'(X_MAX);
   localparam logic [9:0]    Y_LIM = 10'(Y_MAX);
   localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [17:0]   r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic [LW-1:0] w_level_nxt;
   logic          r_full;
   logic          r_empty;
   logic          r_overflow;
   logic [14:0]   r_fb_addr;
   logic [2:0]    r_fb_data;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic          w_req;
   logic          w_offscreen;
   logic [14:0]   w_addr;

   // y*160 + x as shift-adds. 15-bit modular arithmetic gives the required truncation.
   assign w_addr = ({5'b0, bus.y_in} << 7) + ({5'b0, bus.y_in} << 5) + {5'b0, bus.x_in};
   assign w_offscreen = (bus.x_in >= X_LIM) || (bus.y_in >= Y_LIM);

`ifdef PLOT_SINK_CLIP_EN
   assign w_req = bus.plot_in && !w_offscreen;
`else
   assign w_req = bus.plot_in;
`endif

   assign w_push = w_req && (!r_full || w_pop);
   assign w_drop = w_req && r_full && !w_pop;

   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + LW'(1);
         2'b01:   w_level_nxt = r_level - LW'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (r_level != '0) w_state_nxt = S_WRITE;
         S_WRITE: if (bus.fb_ready && (r_level == '0)) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM: outputs. fb_ready only matters once a write is being presented.
   always_comb begin
      w_pop       = 1'b0;
      bus.fb_wren = 1'b0;
      case (r_state)
         S_IDLE:  w_pop = (r_level != '0);
         S_WRITE: begin
            bus.fb_wren = 1'b1;
            w_pop       = bus.fb_ready && (r_level != '0);
         end
         default: begin
            w_pop       = 1'b0;
            bus.fb_wren = 1'b0;
         end
      endcase
   end

   // Storage has no reset; its contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {w_addr, bus.colour_in};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
         r_fb_addr  <= '0;
         r_fb_data  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + PW'(1);
            r_fb_addr <= r_mem[r_rd_ptr][17:3];
            r_fb_data <= r_mem[r_rd_ptr][2:0];
         end
         if (w_drop) r_overflow <= 1'b1;
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == L_FULL);
         r_empty <= (w_level_nxt == '0) && (w_state_nxt == S_IDLE);
      end
   end

   assign bus.fb_addr     = r_fb_addr;
   assign bus.fb_data     = r_fb_data;
   assign level           = r_level;
   assign full            = r_full;
   assign empty           = r_empty;
   assign overflow        = r_overflow;
   assign o_req_offscreen = bus.plot_in && w_offscreen;
   assign o_state_dbg     = r_state;

endmodule

// File: tb/tb_plot_sink.sv
// Self-checking bench for plot_sink: vector table for single-plot and stalled-drain cycles,
// hand sequences for overflow, full push+pop, async reset and off-screen requests.
module tb_plot_sink;

   logic       clk;
   logic       reset;
   logic [4:0] level;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       req_offscreen;
   logic       state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   logic [17:0] exp_q[$];
   logic        hold_pend = 1'b0;
   logic [17:0] hold_val  = '0;

   plot_sink_if bus();

   plot_sink #(.DEPTH(16), .X_MAX(160), .Y_MAX(120)) dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .level           (level),
      .full            (full),
      .empty           (empty),
      .overflow        (overflow),
      .o_req_offscreen (req_offscreen),
      .o_state_dbg     (state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst;
      logic        plot;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [2:0]  c;
      logic        rdy;
      logic        e_wren;
      logic [14:0] e_addr;
      logic [2:0]  e_data;
      logic [4:0]  e_level;
      logic        e_full;
      logic        e_empty;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(input logic rst, input logic plot, input logic [9:0] x,
                               input logic [9:0] y, input logic [2:0] c, input logic rdy,
                               input logic wren, input logic [14:0] addr, input logic [2:0] data,
                               input logic [4:0] lvl, input logic f, input logic e);
      vec_t v;
      v.rst = rst; v.plot = plot; v.x = x; v.y = y; v.c = c; v.rdy = rdy;
      v.e_wren = wren; v.e_addr = addr; v.e_data = data; v.e_level = lvl;
      v.e_full = f; v.e_empty = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic plot, input logic [9:0] x, input logic [9:0] y,
                        input logic [2:0] c, input logic rdy);
      bus.plot_in   = plot;
      bus.x_in      = x;
      bus.y_in      = y;
      bus.colour_in = c;
      bus.fb_ready  = rdy;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, '0, '0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // scoreboard: every completed write must match the head of exp_q, stalled writes must hold
   always @(negedge clk) begin
      if (reset) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("hold_wren", 32'(bus.fb_wren), 32'd1);
            check("hold_addr_data", 32'({bus.fb_addr, bus.fb_data}), 32'(hold_val));
         end
         if (bus.fb_wren && bus.fb_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %0d data %0d expected none at %0t",
                        bus.fb_addr, bus.fb_data, $time);
            end else begin
               check("write_addr_data", 32'({bus.fb_addr, bus.fb_data}), 32'(exp_q.pop_front()));
            end
         end
         hold_pend = bus.fb_wren && !bus.fb_ready;
         hold_val  = {bus.fb_addr, bus.fb_data};
      end
   end

   initial begin
      reset = 1'b1;
      drive(1'b0, '0, '0, '0, 1'b0);

      // single plot, then a 4-entry drain with fb_ready toggling
      vecs[0]  = mk(1, 1,  5,   3, 4, 1,  0,   0, 0, 1, 0, 0);
      vecs[1]  = mk(0, 0,  0,   0, 0, 1,  1, 485, 4, 0, 0, 0);
      vecs[2]  = mk(0, 0,  0,   0, 0, 1,  0, 485, 4, 0, 0, 1);
      vecs[3]  = mk(0, 0,  0,   0, 0, 1,  0, 485, 4, 0, 0, 1);
      vecs[4]  = mk(1, 1, 10,   1, 1, 0,  0,   0, 0, 1, 0, 0);
      vecs[5]  = mk(0, 1, 11,   1, 2, 0,  1, 170, 1, 1, 0, 0);
      vecs[6]  = mk(0, 1, 12,   1, 3, 0,  1, 170, 1, 2, 0, 0);
      vecs[7]  = mk(0, 1, 13,   1, 5, 0,  1, 170, 1, 3, 0, 0);
      vecs[8]  = mk(0, 0,  0,   0, 0, 1,  1, 171, 2, 2, 0, 0);
      vecs[9]  = mk(0, 0,  0,   0, 0, 0,  1, 171, 2, 2, 0, 0);
      vecs[10] = mk(0, 0,  0,   0, 0, 1,  1, 172, 3, 1, 0, 0);
      vecs[11] = mk(0, 0,  0,   0, 0, 0,  1, 172, 3, 1, 0, 0);
      vecs[12] = mk(0, 0,  0,   0, 0, 1,  1, 173, 5, 0, 0, 0);
      vecs[13] = mk(0, 0,  0,   0, 0, 0,  1, 173, 5, 0, 0, 0);
      vecs[14] = mk(0, 0,  0,   0, 0, 1,  0, 173, 5, 0, 0, 1);
      vecs[15] = mk(0, 0,  0,   0, 0, 0,  0, 173, 5, 0, 0, 1);

      // reset state
      do_reset();
      check("rst_level", 32'(level), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_wren", 32'(bus.fb_wren), 32'd0);
      check("rst_addr", 32'(bus.fb_addr), 32'd0);
      check("rst_data", 32'(bus.fb_data), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);

      exp_q.push_back({15'd485, 3'd4});
      exp_q.push_back({15'd170, 3'd1});
      exp_q.push_back({15'd171, 3'd2});
      exp_q.push_back({15'd172, 3'd3});
      exp_q.push_back({15'd173, 3'd5});
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].rst) do_reset();
         drive(vecs[i].plot, vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].rdy);
         tick();
         check($sformatf("v%0d_wren", i), 32'(bus.fb_wren), 32'(vecs[i].e_wren));
         check($sformatf("v%0d_addr", i), 32'(bus.fb_addr), 32'(vecs[i].e_addr));
         check($sformatf("v%0d_data", i), 32'(bus.fb_data), 32'(vecs[i].e_data));
         check($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_level));
         check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
         check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      end
      check("table_drained", 32'(exp_q.size()), 32'd0);

      // 20 plots with fb_ready low: 16 queued, 1 in output stage, 3 dropped
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 10'(i), 10'd0, 3'(i), 1'b0);
         tick();
      end
      drive(1'b0, '0, '0, '0, 1'b0);
      check("ovf_level", 32'(level), 32'd16);
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_overflow", 32'(overflow), 32'd1);
      check("ovf_head_addr", 32'(bus.fb_addr), 32'd0);
      check("ovf_wren", 32'(bus.fb_wren), 32'd1);
      for (int i = 0; i < 17; i++) exp_q.push_back({15'(i), 3'(i)});
      bus.fb_ready = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      check("ovf_b2b_remaining", 32'(exp_q.size()), 32'd1);
      check("ovf_b2b_wren", 32'(bus.fb_wren), 32'd1);
      tick();
      check("ovf_drained", 32'(exp_q.size()), 32'd0);
      check("ovf_idle_wren", 32'(bus.fb_wren), 32'd0);
      check("ovf_empty", 32'(empty), 32'd1);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // full FIFO, write completing and a new plot on the same edge
      do_reset();
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 10'(i), 10'd0, 3'(i), 1'b0);
         tick();
      end
      check("pp_full_before", 32'(full), 32'd1);
      for (int i = 0; i < 17; i++) exp_q.push_back({15'(i), 3'(i)});
      exp_q.push_back({15'd420, 3'd7});
      drive(1'b1, 10'd100, 10'd2, 3'd7, 1'b1);
      tick();
      check("pp_level", 32'(level), 32'd16);
      check("pp_full", 32'(full), 32'd1);
      check("pp_overflow", 32'(overflow), 32'd0);
      check("pp_next_addr", 32'(bus.fb_addr), 32'd1);
      drive(1'b0, '0, '0, '0, 1'b1);
      for (int i = 0; i < 17; i++) tick();
      check("pp_drained", 32'(exp_q.size()), 32'd0);
      check("pp_empty", 32'(empty), 32'd1);
      check("pp_wren", 32'(bus.fb_wren), 32'd0);

      // reset while a write is pending with 5 queued
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 10'(20 + i), 10'd4, 3'd1, 1'b0);
         tick();
      end
      drive(1'b0, '0, '0, '0, 1'b0);
      check("mr_level_before", 32'(level), 32'd5);
      check("mr_wren_before", 32'(bus.fb_wren), 32'd1);
      reset = 1'b1;
      #1;
      check("mr_wren_async", 32'(bus.fb_wren), 32'd0);
      tick();
      reset = 1'b0;
      bus.fb_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("mr_level", 32'(level), 32'd0);
      check("mr_empty", 32'(empty), 32'd1);
      check("mr_wren", 32'(bus.fb_wren), 32'd0);

      // off-screen x followed by the last on-screen pixel
      do_reset();
`ifdef PLOT_SINK_CLIP_EN
      exp_q.push_back({15'd19199, 3'd6});
`else
      exp_q.push_back({15'd160, 3'd2});
      exp_q.push_back({15'd19199, 3'd6});
`endif
      drive(1'b1, 10'd160, 10'd0, 3'd2, 1'b1);
      #1;
      check("clip_offscreen_flag", 32'(req_offscreen), 32'd1);
      tick();
      drive(1'b1, 10'd159, 10'd119, 3'd6, 1'b1);
      #1;
      check("clip_onscreen_flag", 32'(req_offscreen), 32'd0);
      tick();
      drive(1'b0, '0, '0, '0, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      check("clip_drained", 32'(exp_q.size()), 32'd0);
      check("clip_overflow", 32'(overflow), 32'd0);
      check("clip_empty", 32'(empty), 32'd1);

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
